// File: rtl/iexecute.sv
// LEGv8 execute stage: ALU control decode, ALU, branch target and the EX/MEM register.
// Define IEXECUTE_MUL_EN to build the iterative shift-add multiplier that serves MUL.
module iexecute #(
    parameter int WORD = 64
) (
    input  logic            ex_clk,
    input  logic            ex_rst_n,
    input  logic            ex_flush,
    input  logic [WORD-1:0] pc_in,
    input  logic [WORD-1:0] read_data1,
    input  logic [WORD-1:0] read_data2,
    input  logic [WORD-1:0] sign_extend,
    input  logic [10:0]     opcode,
    input  logic [1:0]      alu_op,
    input  logic            alu_src,
    input  logic            branch_in,
    input  logic            uncondbranch_in,
    input  logic            mem_read_in,
    input  logic            mem_write_in,
    input  logic            mem_to_reg_in,
    input  logic            reg_write_in,
    input  logic [4:0]      write_reg_in,
    output logic            ex_busy,
    output logic [WORD-1:0] pc_out,
    output logic [WORD-1:0] alu_result,
    output logic            zero,
    output logic [WORD-1:0] read_data2_out,
    output logic            branch,
    output logic            uncondbranch,
    output logic            mem_read,
    output logic            mem_write,
    output logic            mem_to_reg_out,
    output logic            reg_write_out,
    output logic [4:0]      write_reg_out
);

    localparam logic [10:0] OP_ADD = 11'b10001011000;
    localparam logic [10:0] OP_SUB = 11'b11001011000;
    localparam logic [10:0] OP_AND = 11'b10001010000;
    localparam logic [10:0] OP_ORR = 11'b10101010000;

    logic [WORD-1:0] op_b;
    logic [WORD-1:0] alu_next;
    logic [WORD-1:0] target;

    assign op_b   = alu_src ? sign_extend : read_data2;
    assign target = pc_in + (sign_extend << 2);

`ifdef IEXECUTE_MUL_EN
    localparam logic [10:0] OP_MUL = 11'b10011011000;
    localparam int          CW     = $clog2(WORD);
    localparam logic [CW-1:0] LAST = CW'(WORD - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } mul_state_t;

    mul_state_t      state;
    mul_state_t      state_next;
    logic [WORD-1:0] acc;
    logic [WORD-1:0] mcand;
    logic [WORD-1:0] mplier;
    logic [CW-1:0]   cnt;
    logic            is_mul;

    assign is_mul  = (alu_op == 2'b10) && (opcode == OP_MUL);
    assign ex_busy = is_mul && (state != DONE);

    always_ff @(posedge ex_clk or negedge ex_rst_n) begin
        if (!ex_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (ex_flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (is_mul) state_next = RUN;
                RUN:     if (cnt == LAST) state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // One multiplier bit per edge; a flush leaves the datapath alone since IDLE recaptures it.
    always_ff @(posedge ex_clk or negedge ex_rst_n) begin
        if (!ex_rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (!ex_flush) begin
            if (state == IDLE && is_mul) begin
                acc    <= '0;
                mcand  <= read_data1;
                mplier <= op_b;
                cnt    <= '0;
            end else if (state == RUN) begin
                if (mplier[0]) begin
                    acc <= acc + mcand;
                end
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
            end
        end
    end
`else
    assign ex_busy = 1'b0;
`endif

    always_comb begin
        alu_next = '0;
        case (alu_op)
            2'b00: alu_next = read_data1 + op_b;
            2'b01: alu_next = op_b;
            2'b10: begin
                case (opcode)
                    OP_ADD:  alu_next = read_data1 + op_b;
                    OP_SUB:  alu_next = read_data1 - op_b;
                    OP_AND:  alu_next = read_data1 & op_b;
                    OP_ORR:  alu_next = read_data1 | op_b;
`ifdef IEXECUTE_MUL_EN
                    OP_MUL:  alu_next = acc;
`endif
                    default: alu_next = '0;
                endcase
            end
            default: alu_next = '0;
        endcase
    end

    // A bubble clears control only; data outputs keep their last values.
    always_ff @(posedge ex_clk or negedge ex_rst_n) begin
        if (!ex_rst_n) begin
            pc_out         <= '0;
            alu_result     <= '0;
            zero           <= 1'b0;
            read_data2_out <= '0;
            branch         <= 1'b0;
            uncondbranch   <= 1'b0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_to_reg_out <= 1'b0;
            reg_write_out  <= 1'b0;
            write_reg_out  <= '0;
        end else if (ex_flush || ex_busy) begin
            branch         <= 1'b0;
            uncondbranch   <= 1'b0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_to_reg_out <= 1'b0;
            reg_write_out  <= 1'b0;
            write_reg_out  <= '0;
        end else begin
            pc_out         <= target;
            alu_result     <= alu_next;
            zero           <= (alu_next == '0);
            read_data2_out <= read_data2;
            branch         <= branch_in;
            uncondbranch   <= uncondbranch_in;
            mem_read       <= mem_read_in;
            mem_write      <= mem_write_in;
            mem_to_reg_out <= mem_to_reg_in;
            reg_write_out  <= reg_write_in;
            write_reg_out  <= write_reg_in;
        end
    end

endmodule
